// File: rtl/core_pkg.sv
// Shared types for the Selen core write-back stage: value select, load types, FSM states.
package core_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_IMM  = 2'b11
  } wb_src_t;

  // Load funct3 encodings; anything else is treated as a full word.
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/core_ld_ext.sv
// Load data extraction: picks byte/half/word out of the aligned L1D word and extends it.
module core_ld_ext
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      sx_type,
  input  logic [1:0]      addr,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  assign byte_sh = rdata >> {addr, 3'b000};
  assign half_sh = rdata >> {addr[1], 4'b0000};
  assign byte_v  = byte_sh[7:0];
  assign half_v  = half_sh[15:0];

  always_comb begin
    data     = rdata;
    misalign = (addr != 2'b00);
    case (sx_type)
      LD_LB: begin
        data     = {{(XLEN-8){byte_v[7]}}, byte_v};
        misalign = 1'b0;
      end
      LD_LBU: begin
        data     = {{(XLEN-8){1'b0}}, byte_v};
        misalign = 1'b0;
      end
      LD_LH: begin
        data     = {{(XLEN-16){half_v[15]}}, half_v};
        misalign = addr[0];
      end
      LD_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_v};
        misalign = addr[0];
      end
      default: begin
        data     = rdata;
        misalign = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/core_wb_s.sv
// Write-back stage: retires ALU/PC+4/IMM ops in one cycle, holds loads until L1D ack,
// drives the registered register-file write port and the EXE bypass.
module core_wb_s
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_enb,
  input  logic            wb_kill,
  input  logic            wb_val_in,
  input  logic [1:0]      wb_src_in,
  input  logic            wb_we_reg_file_in,
  input  logic [4:0]      wb_rd_in,
  input  logic [2:0]      wb_sx_type_in,
  input  logic [XLEN-1:0] wb_alu_result_in,
  input  logic [XLEN-1:0] wb_sx_imm_in,
  input  logic [XLEN-1:0] wb_pc_4_in,
  input  logic            l1d2wb_ack_in,
  input  logic [XLEN-1:0] l1d2wb_rdata_in,
  output logic            wb_stall_out,
  output logic            wb_rf_we_out_reg,
  output logic [4:0]      wb_rf_waddr_out_reg,
  output logic [XLEN-1:0] wb_rf_wdata_out_reg,
  output logic [XLEN-1:0] wb2exe_bp_data_out,
  output logic [4:0]      wb2exe_bp_rd_out,
  output logic            wb_err_out_reg
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  wb_state_t       state;
  logic [CW-1:0]   cnt;
  logic [4:0]      cap_rd;
  logic [2:0]      cap_sx;
  logic [1:0]      cap_addr;
  logic            cap_we;

  logic            accept;
  logic [XLEN-1:0] sel_val;
  logic [2:0]      ext_sx;
  logic [1:0]      ext_addr;
  logic [XLEN-1:0] ext_data;
  logic            ext_misalign;

  assign wb_stall_out = (state == ST_WAIT) && !l1d2wb_ack_in;
  assign accept       = wb_enb && !wb_stall_out && wb_val_in && !wb_kill;

  // One extractor serves both phases: misalign check on the incoming op in IDLE,
  // data extraction on the captured op in WAIT.
  assign ext_sx   = (state == ST_WAIT) ? cap_sx   : wb_sx_type_in;
  assign ext_addr = (state == ST_WAIT) ? cap_addr : wb_alu_result_in[1:0];

  core_ld_ext #(.XLEN(XLEN)) u_ld_ext (
    .rdata    (l1d2wb_rdata_in),
    .sx_type  (ext_sx),
    .addr     (ext_addr),
    .data     (ext_data),
    .misalign (ext_misalign)
  );

  always_comb begin
    sel_val = wb_alu_result_in;
    case (wb_src_t'(wb_src_in))
      SRC_PC4: sel_val = wb_pc_4_in;
      SRC_IMM: sel_val = wb_sx_imm_in;
      default: sel_val = wb_alu_result_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      cap_rd              <= '0;
      cap_sx              <= '0;
      cap_addr            <= '0;
      cap_we              <= 1'b0;
      wb_rf_we_out_reg    <= 1'b0;
      wb_rf_waddr_out_reg <= '0;
      wb_rf_wdata_out_reg <= '0;
      wb_err_out_reg      <= 1'b0;
    end else begin
      wb_rf_we_out_reg <= 1'b0;
      wb_err_out_reg   <= 1'b0;
      if (wb_kill) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (wb_src_t'(wb_src_in) == SRC_LOAD) begin
                if (ext_misalign) begin
                  wb_err_out_reg <= 1'b1;
                end else begin
                  state    <= ST_WAIT;
                  cnt      <= '0;
                  cap_rd   <= wb_rd_in;
                  cap_sx   <= wb_sx_type_in;
                  cap_addr <= wb_alu_result_in[1:0];
                  cap_we   <= wb_we_reg_file_in;
                end
              end else if (wb_we_reg_file_in && wb_rd_in != 5'd0) begin
                wb_rf_we_out_reg    <= 1'b1;
                wb_rf_waddr_out_reg <= wb_rd_in;
                wb_rf_wdata_out_reg <= sel_val;
              end
            end
          end
          ST_WAIT: begin
            if (l1d2wb_ack_in) begin
              state <= ST_IDLE;
              if (cap_we && cap_rd != 5'd0) begin
                wb_rf_we_out_reg    <= 1'b1;
                wb_rf_waddr_out_reg <= cap_rd;
                wb_rf_wdata_out_reg <= ext_data;
              end
            end else if (ACK_TIMEOUT != 0 && cnt == TO_LAST) begin
              state          <= ST_IDLE;
              cnt            <= '0;
              wb_err_out_reg <= 1'b1;
            end else if (ACK_TIMEOUT != 0) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wb2exe_bp_data_out = wb_rf_wdata_out_reg;
  assign wb2exe_bp_rd_out   = wb_rf_we_out_reg ? wb_rf_waddr_out_reg : 5'd0;

endmodule

// File: tb/tb_core_wb_s.sv
// Scoreboard bench for core_wb_s: stimulus pushes expected writes/errors, a monitor pops them.
module tb_core_wb_s;

  logic        clk, rst, wb_enb, wb_kill, wb_val_in, wb_we_reg_file_in;
  logic [1:0]  wb_src_in;
  logic [4:0]  wb_rd_in;
  logic [2:0]  wb_sx_type_in;
  logic [31:0] wb_alu_result_in, wb_sx_imm_in, wb_pc_4_in, l1d2wb_rdata_in;
  logic        l1d2wb_ack_in;
  logic        wb_stall_out, wb_rf_we_out_reg, wb_err_out_reg;
  logic [4:0]  wb_rf_waddr_out_reg, wb2exe_bp_rd_out;
  logic [31:0] wb_rf_wdata_out_reg, wb2exe_bp_data_out;

  core_wb_s #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wb_enb(wb_enb), .wb_kill(wb_kill), .wb_val_in(wb_val_in),
    .wb_src_in(wb_src_in), .wb_we_reg_file_in(wb_we_reg_file_in), .wb_rd_in(wb_rd_in),
    .wb_sx_type_in(wb_sx_type_in), .wb_alu_result_in(wb_alu_result_in),
    .wb_sx_imm_in(wb_sx_imm_in), .wb_pc_4_in(wb_pc_4_in),
    .l1d2wb_ack_in(l1d2wb_ack_in), .l1d2wb_rdata_in(l1d2wb_rdata_in),
    .wb_stall_out(wb_stall_out), .wb_rf_we_out_reg(wb_rf_we_out_reg),
    .wb_rf_waddr_out_reg(wb_rf_waddr_out_reg), .wb_rf_wdata_out_reg(wb_rf_wdata_out_reg),
    .wb2exe_bp_data_out(wb2exe_bp_data_out), .wb2exe_bp_rd_out(wb2exe_bp_rd_out),
    .wb_err_out_reg(wb_err_out_reg)
  );

  typedef struct {
    logic        err;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.err = 1'b0; e.rd = rd; e.data = d;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.rd = '0; e.data = '0;
    q.push_back(e);
  endtask

  // Monitor: every write or error pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (wb_rf_we_out_reg || wb_err_out_reg)) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: we=%b err=%b rd=%0d data=%h, none expected",
                   wb_rf_we_out_reg, wb_err_out_reg, wb_rf_waddr_out_reg, wb_rf_wdata_out_reg);
        end else begin
          e = q.pop_front();
          if (e.err) begin
            if (!(wb_err_out_reg && !wb_rf_we_out_reg)) begin
              n_bad++;
              $display("FAIL err_pulse: got we=%b err=%b want we=0 err=1",
                       wb_rf_we_out_reg, wb_err_out_reg);
            end
          end else if (!(wb_rf_we_out_reg && !wb_err_out_reg &&
                         wb_rf_waddr_out_reg == e.rd && wb_rf_wdata_out_reg == e.data &&
                         wb2exe_bp_rd_out == e.rd && wb2exe_bp_data_out == e.data)) begin
            n_bad++;
            $display("FAIL rf_write: got we=%b err=%b rd=%0d data=%h bp_rd=%0d bp_data=%h want rd=%0d data=%h",
                     wb_rf_we_out_reg, wb_err_out_reg, wb_rf_waddr_out_reg, wb_rf_wdata_out_reg,
                     wb2exe_bp_rd_out, wb2exe_bp_data_out, e.rd, e.data);
          end
        end
      end
    end
  end

  // Check stall mid-cycle, then advance to just after the next rising edge.
  task automatic tick(input logic exp_stall);
    @(negedge clk);
    chk("stall", {31'b0, wb_stall_out}, {31'b0, exp_stall});
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] src, input logic [4:0] rd,
                        input logic [2:0] sx, input logic [31:0] alu);
    wb_val_in = 1'b1; wb_src_in = src; wb_we_reg_file_in = 1'b1;
    wb_rd_in = rd; wb_sx_type_in = sx; wb_alu_result_in = alu;
  endtask

  task automatic clr_op();
    wb_val_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stall"}, {31'b0, wb_stall_out}, 32'd0);
    chk({nm, "_we"},    {31'b0, wb_rf_we_out_reg}, 32'd0);
    chk({nm, "_waddr"}, {27'b0, wb_rf_waddr_out_reg}, 32'd0);
    chk({nm, "_wdata"}, wb_rf_wdata_out_reg, 32'd0);
    chk({nm, "_err"},   {31'b0, wb_err_out_reg}, 32'd0);
    chk({nm, "_bp"},    {wb2exe_bp_data_out[26:0], wb2exe_bp_rd_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wb_enb = 1'b1; wb_kill = 1'b0; wb_val_in = 1'b0; wb_src_in = 2'b00;
    wb_we_reg_file_in = 1'b0; wb_rd_in = '0; wb_sx_type_in = '0; wb_alu_result_in = '0;
    wb_sx_imm_in = '0; wb_pc_4_in = '0; l1d2wb_ack_in = 1'b0; l1d2wb_rdata_in = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op, PC+4 op, IMM op: one-cycle retire, never stalls
    set_op(2'b00, 5'd5, 3'b000, 32'h1234_5678); push_wr(5'd5, 32'h1234_5678);
    tick(1'b0); clr_op(); tick(1'b0);
    set_op(2'b10, 5'd3, 3'b000, 32'h0); wb_pc_4_in = 32'h0000_0104; push_wr(5'd3, 32'h0000_0104);
    tick(1'b0);
    set_op(2'b11, 5'd4, 3'b000, 32'h0); wb_sx_imm_in = 32'hFFFF_F800; push_wr(5'd4, 32'hFFFF_F800);
    tick(1'b0); clr_op(); tick(1'b0);

    // LB at byte 3, ack after two wait cycles; then LBU
    set_op(2'b01, 5'd6, 3'b000, 32'h0000_1003); push_wr(5'd6, 32'hFFFF_FF80);
    tick(1'b0); clr_op(); tick(1'b1); tick(1'b1);
    l1d2wb_ack_in = 1'b1; l1d2wb_rdata_in = 32'h80AA_BBCC;
    tick(1'b0); l1d2wb_ack_in = 1'b0; tick(1'b0);
    set_op(2'b01, 5'd11, 3'b100, 32'h0000_1003); push_wr(5'd11, 32'h0000_0080);
    tick(1'b0); clr_op(); tick(1'b1); tick(1'b1);
    l1d2wb_ack_in = 1'b1;
    tick(1'b0); l1d2wb_ack_in = 1'b0; tick(1'b0);

    // LH upper half, ack in first wait cycle
    set_op(2'b01, 5'd12, 3'b001, 32'h0000_2002); push_wr(5'd12, 32'hFFFF_8001);
    tick(1'b0); clr_op();
    l1d2wb_ack_in = 1'b1; l1d2wb_rdata_in = 32'h8001_7FFF;
    tick(1'b0); l1d2wb_ack_in = 1'b0; tick(1'b0);

    // Misaligned LW: error pulse, no stall, no write
    set_op(2'b01, 5'd13, 3'b010, 32'h0000_3001); push_err();
    tick(1'b0); clr_op(); tick(1'b0); tick(1'b0);

    // Timeout: four stall cycles, error pulse, then a late ack is ignored
    set_op(2'b01, 5'd7, 3'b010, 32'h0000_4000); push_err();
    tick(1'b0); clr_op();
    for (int i = 0; i < 4; i++) tick(1'b1);
    tick(1'b0);
    l1d2wb_ack_in = 1'b1; l1d2wb_rdata_in = 32'hCAFE_F00D;
    tick(1'b0); l1d2wb_ack_in = 1'b0; tick(1'b0);

    // Kill together with ack: ack dropped, back in IDLE
    set_op(2'b01, 5'd8, 3'b010, 32'h0000_5008);
    tick(1'b0); clr_op();
    l1d2wb_ack_in = 1'b1; wb_kill = 1'b1;
    tick(1'b0); l1d2wb_ack_in = 1'b0; wb_kill = 1'b0;
    tick(1'b0); tick(1'b0);

    // Load then ALU op to rd=0 presented in the ack cycle and held one more cycle
    set_op(2'b01, 5'd9, 3'b010, 32'h0000_6004); push_wr(5'd9, 32'hDEAD_BEEF);
    tick(1'b0);
    l1d2wb_ack_in = 1'b1; l1d2wb_rdata_in = 32'hDEAD_BEEF;
    set_op(2'b00, 5'd0, 3'b000, 32'h0000_0055);
    tick(1'b0); l1d2wb_ack_in = 1'b0;
    tick(1'b0); clr_op();
    @(negedge clk);
    chk("rd0_we", {31'b0, wb_rf_we_out_reg}, 32'd0);
    chk("rd0_bp_rd", {27'b0, wb2exe_bp_rd_out}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of WAIT clears everything immediately
    set_op(2'b01, 5'd10, 3'b010, 32'h0000_7000);
    tick(1'b0); clr_op(); tick(1'b1);
    chk("pre_rst_stall", {31'b0, wb_stall_out}, 32'd1);
    rst = 1'b1; #1;
    chk_all_zero("mid_rst");
    #2; rst = 1'b0;
    tick(1'b0);

    // Recovery after reset
    set_op(2'b00, 5'd1, 3'b000, 32'hA5A5_A5A5); push_wr(5'd1, 32'hA5A5_A5A5);
    tick(1'b0); clr_op(); tick(1'b0); tick(1'b0);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_wb_s.md
Name: core_wb_s

Overview:
Write-back stage of the Selen core pipeline, directly downstream of the memory stage. It captures the memory-stage register outputs, waits for the L1D response on loads, and extracts and sign/zero-extends the load data. It selects the write-back value (ALU, load, PC+4 or immediate) and drives a registered register-file write port plus a bypass path to EXE. A stall output freezes upstream stages while a load is outstanding.

Parameters:
XLEN, 32, datapath width
ACK_TIMEOUT, 255, max cycles waiting for l1d_ack before abort; 0 disables the timeout

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
wb_enb  in  1  stage enable; capture allowed when wb_enb=1 and wb_stall_out=0
wb_kill  in  1  flush; drops captured/outstanding op
wb_val_in  in  1  valid op from mem stage
wb_src_in  in  2  value select: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
wb_we_reg_file_in  in  1  op writes rd
wb_rd_in  in  5  destination register
wb_sx_type_in  in  3  load type (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
wb_alu_result_in  in  XLEN  ALU result / load address
wb_sx_imm_in  in  XLEN  sign-extended immediate
wb_pc_4_in  in  XLEN  PC+4
l1d2wb_ack_in  in  1  L1D response valid
l1d2wb_rdata_in  in  XLEN  L1D read word (aligned)
wb_stall_out  out  1  freeze upstream (combinational)
wb_rf_we_out_reg  out  1  register-file write enable
wb_rf_waddr_out_reg  out  5  register-file write address
wb_rf_wdata_out_reg  out  XLEN  register-file write data
wb2exe_bp_data_out  out  XLEN  bypass data (= wb_rf_wdata_out_reg)
wb2exe_bp_rd_out  out  5  bypass rd (= wb_rf_waddr_out_reg, 0 when wb_rf_we_out_reg=0)
wb_err_out_reg  out  1  one-cycle pulse: misaligned load or ack timeout

Behaviour:
- Reset: state IDLE, timeout counter 0, captured op cleared, all *_out_reg outputs 0, wb_stall_out=0.
- States: IDLE, WAIT. accept = wb_enb & ~wb_stall_out & wb_val_in & ~wb_kill.
- IDLE, accept of non-load (src!=01): at the next edge rf_we<=we&(rd!=0), waddr<=rd, wdata<=selected value. Latency 1 cycle.
- IDLE, accept of load: capture rd/sx_type/addr[1:0]/we. Go to WAIT, clear counter. rf_we<=0.
- WAIT: wb_stall_out = ~l1d2wb_ack_in. On ack: extract and extend the data, rf_we<=we&(rd!=0), go to IDLE. Stall drops in the ack cycle, so a new op may be accepted in that same cycle. The new op is evaluated from IDLE next cycle and is held by the upstream register.
- Extraction: LB/LBU take rdata[8*addr[1:0]+:8]; LH/LHU take rdata[16*addr[1]+:16]; LW takes the whole word. LB/LH sign-extend; LBU/LHU zero-extend. Reserved sx_type codes behave as LW.
- Misaligned load (LH/LHU with addr[0]=1, LW with addr[1:0]!=0): detected at accept. Do not enter WAIT; no rf write; wb_err pulse next cycle.
- Timeout: counter increments each WAIT cycle without ack. At count==ACK_TIMEOUT-1 without ack: go to IDLE, no write, wb_err pulse, stall released. A late ack arriving in IDLE is ignored.
- wb_kill: highest priority. In any state: go to IDLE, rf_we<=0, counter cleared, no err pulse. Kill in the same cycle as ack: the ack is discarded.
- rf_we is a single-cycle pulse per retired op; waddr/wdata hold their last value when rf_we=0.
- Reset asserted mid-WAIT: immediate return to IDLE, outputs cleared asynchronously.

Decomposition:
- Shared package core_pkg: wb_src_t (ALU/LOAD/PC4/IMM), load sx_type constants (LB..LHU), wb_state_t (IDLE/WAIT).
- One combinational sub-module core_ld_ext: inputs rdata, sx_type, addr[1:0]; outputs extended data and misalign flag.

Test Plan:
- ALU op, rd=5, alu=0x1234_5678, src=00 -> next cycle rf_we=1, waddr=5, wdata=0x1234_5678, stall=0 throughout.
- LB addr[1:0]=3, ack after 2 wait cycles with rdata=0x80AA_BBCC -> stall high 2 cycles, then wdata=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- LH addr=0x...2, rdata=0x8001_7FFF -> wdata=0xFFFF_8001. LW addr=0x...1 -> no write, wb_err pulse, no stall.
- Load with no ack, ACK_TIMEOUT=4 -> stall for exactly 4 cycles, wb_err pulse, rf_we stays 0. A late ack is then ignored.
- Load pending, wb_kill asserted together with ack -> no rf write, state IDLE, stall=0 next cycle.
- Back-to-back load then ALU op (rd=0) -> load written in the ack cycle+1, ALU op retired with rf_we=0 because rd=0. Also assert rst mid-WAIT -> all outputs 0 immediately.
